// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared types for the ID decode stage.
//   itype_e     : instruction type encoding (R=0, J=1, HALT=2, I=3)
//   state_e     : decode-stage control FSM states
//   dec_entry_t : decoded entry layout at the default widths. The top packs
//                 its parametrised entry with the same field order, so the
//                 struct documents the bit layout of the skid-buffer payload.
//   entry_w()   : payload width for a given XLEN/RAW.
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RAW_DEF   = 5;
    localparam int IMM_W_DEF = 15;
    localparam int JA_W_DEF  = 26;

    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_J    = 2'd1,
        IT_HALT = 2'd2,
        IT_I    = 2'd3
    } itype_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        itype_e              itype;
        logic [RAW_DEF-1:0]  ra1;
        logic [RAW_DEF-1:0]  ra2;
        logic [RAW_DEF-1:0]  wa;
        logic [4:0]          sa;
        logic [5:0]          funct;
        logic [XLEN_DEF-1:0] imm;
        logic [XLEN_DEF-1:0] jtarget;
        logic [XLEN_DEF-1:0] pc;
    } dec_entry_t;

    // type + 3 register addresses + sa + funct + imm/jtarget/pc
    function automatic int entry_w(input int xlen, input int raw);
        return 2 + 3 * raw + 5 + 6 + 3 * xlen;
    endfunction

endpackage

// File: rtl/id_skid_buf.sv
// ---------------------------------------------------------------------------
// id_skid_buf
// Generic 2-entry valid/ready skid register (main + skid).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : drop both entries (priority over push/pop)
//   in_valid / in_ready : upstream handshake; in_ready = skid slot free
//   in_data  [W]        : payload
//   out_valid/out_ready : downstream handshake, driven from the main slot
//   out_data [W]        : main slot payload, stable while stalled
// in_ready depends only on flops, so upstream never sees a combinational
// path from out_ready.
// ---------------------------------------------------------------------------
module id_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         push, pop;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        push         = in_valid && !skid_valid_q;
        pop          = main_valid_q && out_ready;

        if (clear) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            // Empty buffer: new entry lands directly in main.
            if (push) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                // Older skid entry is promoted; push cannot occur (in_ready=0).
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                // Simultaneous consume and accept keeps 1 entry/cycle throughput.
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            // Main stalled: park the new entry behind it.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
// Handshaked ID stage: decodes pre-split instruction fields into register
// read/write addresses, extended immediate and jump target, buffers them in
// a 2-entry skid buffer and runs a RUN/DRAIN/HALTED control FSM.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid/in_ready             : upstream handshake (in_ready from flops)
//   in_type, in_rs/rt/rd, in_sa, in_funct, in_imm, in_jaddr, in_pc : fields
//   flush                         : drop held and incoming work (not in HALTED)
//   out_valid/out_ready           : downstream handshake
//   out_type, out_ra1/ra2/wa, out_sa, out_funct, out_imm, out_jtarget,
//   out_pc                        : decoded entry
//   halted                        : FSM is in HALTED (left only by reset)
// Optional (macro ID_PERF_CNT_EN): stall_cnt, instr_cnt saturating counters.
// ---------------------------------------------------------------------------
module id_decode_stage
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int IMM_W = 15,
    parameter int JA_W  = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_type,
    input  logic [RAW-1:0]  in_rs,
    input  logic [RAW-1:0]  in_rt,
    input  logic [RAW-1:0]  in_rd,
    input  logic [4:0]      in_sa,
    input  logic [5:0]      in_funct,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [JA_W-1:0] in_jaddr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_type,
    output logic [RAW-1:0]  out_ra1,
    output logic [RAW-1:0]  out_ra2,
    output logic [RAW-1:0]  out_wa,
    output logic [4:0]      out_sa,
    output logic [5:0]      out_funct,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_jtarget,
    output logic [XLEN-1:0] out_pc,
    output logic            halted
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    localparam int EW = entry_w(XLEN, RAW);

    state_e          state_q, state_d;
    logic            halted_q, halted_d;

    logic [RAW-1:0]  dec_ra1, dec_ra2, dec_wa;
    logic [4:0]      dec_sa;
    logic [5:0]      dec_funct;
    logic [XLEN-1:0] dec_imm, dec_jtarget;
    logic [EW-1:0]   dec_entry, buf_out_data;

    logic buf_in_valid, buf_in_ready, buf_out_valid, buf_clear;
    logic accept, consume;

    // ---------------- decode ----------------
    always_comb begin
        dec_ra1     = '0;
        dec_ra2     = '0;
        dec_wa      = '0;
        dec_sa      = in_sa;
        dec_funct   = in_funct;
        dec_imm     = '0;
        dec_jtarget = '0;
        case (itype_e'(in_type))
            IT_R: begin
                dec_ra1 = in_rs;
                dec_ra2 = in_rt;
                dec_wa  = in_rd;
            end
            IT_I: begin
                dec_ra1 = in_rs;
                dec_ra2 = in_rt;
                dec_wa  = in_rt;
                dec_imm = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
            end
            IT_J: begin
                dec_jtarget = {in_pc[XLEN-1:JA_W], in_jaddr};
            end
            IT_HALT: begin
                dec_sa    = '0;
                dec_funct = '0;
            end
            default: ;
        endcase
    end

    // Field order matches id_pkg::dec_entry_t.
    assign dec_entry = {in_type, dec_ra1, dec_ra2, dec_wa, dec_sa, dec_funct,
                        dec_imm, dec_jtarget, in_pc};

    // ---------------- handshake ----------------
    // Flush wins over accept and consume in the same cycle; HALTED ignores it.
    assign buf_clear    = flush && (state_q != ST_HALTED);
    assign buf_in_valid = in_valid && (state_q == ST_RUN) && !flush;
    assign in_ready     = buf_in_ready && (state_q == ST_RUN);
    assign accept       = buf_in_valid && buf_in_ready;
    assign out_valid    = buf_out_valid && (state_q != ST_HALTED);
    assign consume      = out_valid && out_ready && !flush;

    id_skid_buf #(.W(EW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (buf_clear),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (dec_entry),
        .out_valid (buf_out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_data)
    );

    assign {out_type, out_ra1, out_ra2, out_wa, out_sa, out_funct,
            out_imm, out_jtarget, out_pc} = buf_out_data;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            ST_RUN: begin
                if (accept && itype_e'(in_type) == IT_HALT) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (consume && itype_e'(out_type) == IT_HALT) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

`ifdef ID_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (buf_clear) begin
            stall_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
            if (consume && instr_cnt_q != '1)                 instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_id_decode_stage
// Self-checking bench for id_decode_stage. Expected decoded entries are
// pushed to a queue on every accepted transfer and popped/compared on every
// downstream consume; scenario tasks add direct checks of handshake, FSM,
// flush and reset behaviour.
// ---------------------------------------------------------------------------
module tb_id_decode_stage;
    import id_pkg::*;

    localparam int EW = id_pkg::entry_w(32, 5);

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [4:0]  in_rs, in_rt, in_rd, in_sa;
    logic [5:0]  in_funct;
    logic [14:0] in_imm;
    logic [25:0] in_jaddr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_type;
    logic [4:0]  out_ra1, out_ra2, out_wa, out_sa;
    logic [5:0]  out_funct;
    logic [31:0] out_imm, out_jtarget, out_pc;
    logic        halted;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] sb[$];

    id_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_sa       (in_sa),
        .in_funct    (in_funct),
        .in_imm      (in_imm),
        .in_jaddr    (in_jaddr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_type    (out_type),
        .out_ra1     (out_ra1),
        .out_ra2     (out_ra2),
        .out_wa      (out_wa),
        .out_sa      (out_sa),
        .out_funct   (out_funct),
        .out_imm     (out_imm),
        .out_jtarget (out_jtarget),
        .out_pc      (out_pc),
        .halted      (halted)
`ifdef ID_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode, written from the instruction-type table.
    function automatic logic [EW-1:0] model(input logic [1:0] t, input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
            input logic [5:0] fn, input logic [14:0] imm, input logic [25:0] ja,
            input logic [31:0] pc);
        logic [4:0]  r1, r2, w, s;
        logic [5:0]  f;
        logic [31:0] ie, jt;
        r1 = '0; r2 = '0; w = '0; s = sa; f = fn; ie = '0; jt = '0;
        case (t)
            2'd0: begin r1 = rs; r2 = rt; w = rd; end
            2'd3: begin r1 = rs; r2 = rt; w = rt; ie = {{17{imm[14]}}, imm}; end
            2'd1: jt = {pc[31:26], ja};
            default: begin s = '0; f = '0; end
        endcase
        return {t, r1, r2, w, s, f, ie, jt, pc};
    endfunction

    task automatic drive(input logic [1:0] t, input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [14:0] imm, input logic [25:0] ja,
            input logic [31:0] pc);
        in_valid = 1'b1;
        in_type  = t;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_sa    = 5'($urandom);
        in_funct = 6'($urandom);
        in_imm   = imm;
        in_jaddr = ja;
        in_pc    = pc;
    endtask

    // One clock: record the transfers the coming edge will perform, then
    // advance to the following falling edge where outputs are sampled.
    task automatic cycle();
        logic acc, con;
        logic [EW-1:0] got, exp;
        acc = rst_n && in_valid && in_ready && !flush;
        con = rst_n && out_valid && out_ready && !flush;
        got = {out_type, out_ra1, out_ra2, out_wa, out_sa, out_funct, out_imm, out_jtarget, out_pc};
        if (!rst_n || (flush && !halted)) begin
            sb.delete();
        end else begin
            if (con) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output: got entry %0h expected no output", got);
                end else begin
                    exp = sb.pop_front();
                    $display("consume: type=%0d wa=%0d pc=%08h", out_type, out_wa, out_pc);
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_entry: got %0h expected %0h", got, exp);
                    end
                end
            end
            if (acc) begin
                sb.push_back(model(in_type, in_rs, in_rt, in_rd, in_sa, in_funct, in_imm, in_jaddr, in_pc));
                $display("accept:  type=%0d rs=%0d rt=%0d rd=%0d pc=%08h", in_type, in_rs, in_rt, in_rd, in_pc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        checks++; if (out_imm !== 32'h0 || out_pc !== 32'h0 || out_wa !== 5'd0) begin
            errors++; $display("FAIL reset_data: got imm=%0h pc=%0h wa=%0d expected 0", out_imm, out_pc, out_wa); end
        rst_n = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        drive(2'd3, 5'd3, 5'd7, 5'd9, 15'h4000, 26'h0, 32'h0000_0100);
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL itype_latency: got out_valid=%0b expected 1", out_valid); end
        checks++; if (out_ra1 !== 5'd3 || out_ra2 !== 5'd7 || out_wa !== 5'd7) begin
            errors++; $display("FAIL itype_addr: got %0d/%0d/%0d expected 3/7/7", out_ra1, out_ra2, out_wa); end
        checks++; if (out_imm !== 32'hFFFF_C000) begin errors++; $display("FAIL itype_imm: got %08h expected FFFFC000", out_imm); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL itype_drain: got out_valid=%0b expected 0", out_valid); end
    endtask

    task automatic test_jtype();
        out_ready = 1'b1;
        drive(2'd1, 5'd5, 5'd6, 5'd7, 15'h1234, 26'h0000123, 32'hFC00_0010);
        cycle();
        in_valid = 1'b0;
        checks++; if (out_jtarget !== 32'hFC00_0123) begin errors++; $display("FAIL jtype_target: got %08h expected FC000123", out_jtarget); end
        checks++; if (out_ra1 !== 5'd0 || out_ra2 !== 5'd0 || out_wa !== 5'd0) begin
            errors++; $display("FAIL jtype_addr: got %0d/%0d/%0d expected 0/0/0", out_ra1, out_ra2, out_wa); end
        cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(2'd0, 5'd1, 5'd2, 5'd3, 15'h0, 26'h0, 32'h0000_1000);
        cycle();
        drive(2'd0, 5'd4, 5'd5, 5'd6, 15'h0, 26'h0, 32'h0000_1004);
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %0b expected 0", in_ready); end
        drive(2'd0, 5'd7, 5'd8, 5'd9, 15'h0, 26'h0, 32'h0000_1008);
        cycle();
        checks++; if (out_valid !== 1'b1 || out_wa !== 5'd3) begin
            errors++; $display("FAIL b2b_hold: got valid=%0b wa=%0d expected 1/3", out_valid, out_wa); end
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_wa !== 5'd6) begin
            errors++; $display("FAIL b2b_promote: got valid=%0b wa=%0d expected 1/6", out_valid, out_wa); end
        cycle();
        checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_empty: got valid=%0b pending=%0d expected 0/0", out_valid, sb.size()); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(2'(i % 2 == 0 ? 0 : 3), 5'(i), 5'(i + 1), 5'(i + 10), 15'($urandom), 26'h0, 32'h2000 + 32'(i * 4));
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL stream_empty: got valid=%0b pending=%0d expected 0/0", out_valid, sb.size()); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(2'd0, 5'd1, 5'd1, 5'd11, 15'h0, 26'h0, 32'h3000);
        cycle();
        drive(2'd0, 5'd2, 5'd2, 5'd12, 15'h0, 26'h0, 32'h3004);
        cycle();
        drive(2'd0, 5'd3, 5'd3, 5'd13, 15'h0, 26'h0, 32'h3008);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %0b expected 0", out_valid); end
        // flush out of DRAIN returns to RUN
        drive(2'd2, 5'd0, 5'd0, 5'd0, 15'h0, 26'h0, 32'h3100);
        cycle();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready: got %0b expected 0", in_ready); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL drain_flush: got ready=%0b valid=%0b halted=%0b expected 1/0/0", in_ready, out_valid, halted); end
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        drive(2'd2, 5'd4, 5'd4, 5'd4, 15'h7FFF, 26'h3FF, 32'h0000_0200);
        cycle();
        drive(2'd0, 5'd1, 5'd2, 5'd3, 15'h0, 26'h0, 32'h0000_0204);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_block: got in_ready=%0b expected 0", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_type !== 2'd2) begin
            errors++; $display("FAIL halt_head: got valid=%0b type=%0d expected 1/2", out_valid, out_type); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        checks++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL halt_state: got halted=%0b ready=%0b valid=%0b expected 1/0/0", halted, in_ready, out_valid); end
        in_valid = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        checks++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL halt_sticky: got halted=%0b ready=%0b valid=%0b expected 1/0/0", halted, in_ready, out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL halt_exit_reset: got halted=%0b ready=%0b expected 0/1", halted, in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(2'd3, 5'd9, 5'd10, 5'd0, 15'h0055, 26'h0, 32'h4000);
        cycle();
        drive(2'd1, 5'd0, 5'd0, 5'd0, 15'h0, 26'h2AAAAAA, 32'h4004);
        cycle();
`ifdef ID_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL perf_stall: got %0d expected 1", stall_cnt); end
`endif
        drive(2'd0, 5'd1, 5'd2, 5'd3, 15'h0, 26'h0, 32'h4008);
        rst_n = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
        checks++; if (out_type !== 2'd0 || out_wa !== 5'd0 || out_imm !== 32'h0 || out_jtarget !== 32'h0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL rstmid_data: got type=%0d wa=%0d imm=%0h jt=%0h pc=%0h expected 0", out_type, out_wa, out_imm, out_jtarget, out_pc); end
`ifdef ID_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_perf: got stall=%0d instr=%0d expected 0/0", stall_cnt, instr_cnt); end
`endif
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_after: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_type   = 2'd0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_sa     = '0;
        in_funct  = '0;
        in_imm    = '0;
        in_jaddr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        test_reset();
        test_itype();
        test_jtype();
        test_back_to_back();
        test_stream();
        test_flush();
        test_halt();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Parametrised, handshaked successor to the ID-stage control unit.
- Accepts pre-split instruction fields from IF/split logic.
- Produces register-file read addresses, the extended immediate and the jump target.
- Holds results in a 2-entry skid buffer so upstream stall is registered.
- Adds flush support and a HALT state machine; sits between the instruction splitter and the register-file/EX pipeline register.

Parameters:
- XLEN, 32, datapath/PC width.
- RAW, 5, register address width.
- IMM_W, 15, immediate field width (must be < XLEN).
- JA_W, 26, jump address field width (must be < XLEN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream fields valid.
- in_ready  out  1  stage can accept (registered).
- in_type  in  2  instruction type: R=0, J=1, HALT=2, I=3.
- in_rs, in_rt, in_rd  in  RAW  register fields.
- in_sa  in  5  shift amount.
- in_funct  in  6  function code.
- in_imm  in  IMM_W  immediate field.
- in_jaddr  in  JA_W  jump address field.
- in_pc  in  XLEN  PC of instruction.
- flush  in  1  discard all held/incoming work.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_type  out  2  passthrough type.
- out_ra1, out_ra2, out_wa  out  RAW  read addr 1/2, write addr.
- out_sa  out  5; out_funct  out  6  passthrough.
- out_imm  out  XLEN  extended immediate.
- out_jtarget  out  XLEN  jump target.
- out_pc  out  XLEN  passthrough PC.
- halted  out  1  FSM in HALTED.

Behaviour:
- Transfer occurs when valid & ready on the same clk edge; latency from accept to out_valid is 1 cycle when the buffer is empty.
- Decode:
  - R: ra1=rs, ra2=rt, wa=rd, imm=0, jtarget=0.
  - I: ra1=rs, ra2=rt, wa=rt, imm = sign-extend in_imm[IMM_W-1] to XLEN.
  - J: ra1=ra2=wa=0, jtarget = {in_pc[XLEN-1:JA_W], in_jaddr}.
  - HALT: all fields 0.
- Skid buffer: main register plus skid register.
  - in_ready = !skid_full & state==RUN.
  - Accept while main is full and !out_ready: entry goes to skid.
  - On out_ready with skid full: skid moves to main, skid clears.
  - Order is preserved.
- FSM:
  - RUN -> DRAIN when a HALT-type entry is accepted; in_ready=0 from the next cycle.
  - DRAIN -> HALTED when the HALT entry is consumed downstream (out_valid & out_ready & out_type==HALT).
  - HALTED: in_ready=0, out_valid=0, halted=1; exit only by reset.
- Flush:
  - Same-cycle priority over accept and downstream consume.
  - Next cycle: main/skid empty, out_valid=0, state RUN (also from DRAIN).
  - HALTED ignores flush.
- Reset (rst_n=0 at edge): out_valid=0, skid empty, state RUN, halted=0, all data outputs 0; in_ready=1 the cycle after reset deasserts.
- Reset mid-transfer: any in-flight entry is lost, with no partial output.
- Simultaneous accept and consume with main full and skid empty: new entry goes straight into main (throughput 1/cycle).
- Data outputs are stable while out_valid & !out_ready.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- When defined, adds outputs stall_cnt (32) and instr_cnt (32).
  - stall_cnt increments each cycle out_valid & !out_ready.
  - instr_cnt increments per downstream consume.
  - Both saturate at all-ones, reset to 0, and are cleared by flush.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package id_pkg holds:
  - itype_e enum (R=0, J=1, HALT=2, I=3);
  - state enum (RUN, DRAIN, HALTED);
  - a packed decoded-entry struct (type, ra1, ra2, wa, sa, funct, imm, jtarget, pc).
- One sub-module id_skid_buf: generic 2-entry valid/ready skid register over the struct.
- Decode logic and FSM stay in the top module.

Test Plan:
- I-type, in_imm=15'h4000, rs=3, rt=7, out_ready=1 -> 1 cycle later out_valid=1, ra1=3, ra2=7, wa=7, imm=32'hFFFFC000.
- J-type, pc=32'hFC00_0010, jaddr=26'h0000123 -> jtarget=32'hFC00_0123, ra1=ra2=0.
- Back-to-back R-types with out_ready=0 for 3 cycles -> two entries held, in_ready=0 after the second, order preserved on release, no loss/duplication.
- HALT accepted then R offered -> R not accepted; after HALT consumed, halted=1, in_ready=0 until rst_n pulse.
- flush asserted while skid full and in_valid=1 -> next cycle out_valid=0, incoming entry dropped, in_ready=1.
- rst_n=0 mid-stream for 1 cycle -> all outputs 0, out_valid=0; with ID_PERF_CNT_EN, counters read 0.
